// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
//   Shared constants and helpers for the modulo counter and its prescaler.
//   WRAP_CNT_W   : width of the saturating wrap counter output.
//   PRESCALE_MAX : largest supported prescale ratio.
//   pre_width()  : bits needed for the prescaler count (clog2, minimum 1).
package mod_counter_pkg;

  localparam int WRAP_CNT_W   = 8;
  localparam int PRESCALE_MAX = 256;

  // Prescaler count runs 0..prescale-1, so clog2(prescale) bits suffice;
  // a ratio of 1 still gets a 1-bit register so the port list stays uniform.
  function automatic int pre_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler
//   Divides enabled cycles by PRESCALE and emits a one-cycle tick on every
//   PRESCALE-th enabled cycle. The count only advances while en is high.
// Ports:
//   clk      in  clock
//   rstn     in  synchronous active-low reset
//   en       in  count enable
//   sync_clr in  synchronous restart of the prescale count
//   tick     out en & (pre == PRESCALE-1), combinational from the register
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESCALE < 1 || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE out of range 1..256");
    end
  endgenerate

  localparam int              PW       = pre_width(PRESCALE);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_reg;
  logic [PW-1:0] pre_next;

  // With PRESCALE=1 PRE_LAST is 0, so pre never leaves 0 and tick == en.
  assign tick = en & (pre_reg == PRE_LAST);

  always_comb begin
    pre_next = pre_reg;
    if (sync_clr) begin
      pre_next = '0;
    end else if (en) begin
      pre_next = tick ? '0 : pre_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_next;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter
//   Modulo up/down counter with prescaler, synchronous clear/load,
//   registered terminal-count pulse and saturating wrap counter.
//   Build option: define MOD_COUNTER_SAT_EN to make the counter saturate at
//   its bounds instead of wrapping (tc then marks arrival at the bound and
//   wrap_cnt stays 0).
// Ports:
//   clk      in  clock
//   rstn     in  synchronous active-low reset (highest priority)
//   en       in  count enable (feeds the prescaler)
//   up       in  1 = increment, 0 = decrement; sampled on tick cycles only
//   clr      in  synchronous clear (beats load and step)
//   load     in  synchronous load of load_val (beats step)
//   load_val in  load value; values >= MODULUS clamp to MODULUS-1
//   out      out current count, straight from the register
//   tc       out registered one-cycle terminal-count pulse
//   wrap_cnt out wraps since reset/clr, saturating at 255
//   load_err out sticky: an out-of-range load was clamped
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  load_err
);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS out of range 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range test.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]      count_reg, count_next;
  logic                  tc_reg, tc_next;
  logic [WRAP_CNT_W-1:0] wrap_reg, wrap_next;
  logic                  err_reg, err_next;
  logic                  tick;
  logic                  load_oor;
  logic [WIDTH-1:0]      count_inc, count_dec;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  assign load_oor  = ({1'b0, load_val} >= MOD_EXT);
  assign count_inc = count_reg + 1'b1;
  assign count_dec = count_reg - 1'b1;

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    wrap_next  = wrap_reg;
    err_next   = err_reg;

    if (clr) begin
      count_next = '0;
      wrap_next  = '0;
      err_next   = 1'b0;
    end else if (load) begin
      if (load_oor) begin
        count_next = LAST;
        err_next   = 1'b1;
      end else begin
        count_next = load_val;
      end
    end else if (tick) begin
      if (up) begin
        if (count_reg == LAST) begin
`ifdef MOD_COUNTER_SAT_EN
          count_next = LAST;
`else
          count_next = '0;
          tc_next    = 1'b1;
          if (wrap_reg != {WRAP_CNT_W{1'b1}}) wrap_next = wrap_reg + 1'b1;
`endif
        end else begin
          count_next = count_inc;
`ifdef MOD_COUNTER_SAT_EN
          tc_next    = (count_inc == LAST);
`endif
        end
      end else begin
        if (count_reg == '0) begin
`ifdef MOD_COUNTER_SAT_EN
          count_next = '0;
`else
          count_next = LAST;
          tc_next    = 1'b1;
          if (wrap_reg != {WRAP_CNT_W{1'b1}}) wrap_next = wrap_reg + 1'b1;
`endif
        end else begin
          count_next = count_dec;
`ifdef MOD_COUNTER_SAT_EN
          tc_next    = (count_dec == '0);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      wrap_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign out      = count_reg;
  assign tc       = tc_reg;
  assign wrap_cnt = wrap_reg;
  assign load_err = err_reg;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter
//   Drives three counter instances with the same stimulus:
//     u0: WIDTH=5 MODULUS=10 PRESCALE=1
//     u1: WIDTH=5 MODULUS=10 PRESCALE=3
//     u2: WIDTH=1 MODULUS=2  PRESCALE=1 (modulus equals 2**WIDTH)
//   A behavioural model predicts each edge; predictions are queued when the
//   inputs are driven and popped after the edge. Directed constant checks
//   pin the key waypoints. Honours MOD_COUNTER_SAT_EN like the design.
module tb_mod_counter;

`ifdef MOD_COUNTER_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  typedef struct {
    int out;
    int tc;
    int wrap;
    int err;
    int pre;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, en, up, clr, load;
  logic [4:0] lv;

  logic [4:0] out0, out1;
  logic [0:0] out2;
  logic       tc0, tc1, tc2, e0, e1, e2;
  logic [7:0] w0, w1, w2;

  mod_counter #(.WIDTH(5), .MODULUS(10), .PRESCALE(1)) u0 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .out(out0), .tc(tc0), .wrap_cnt(w0), .load_err(e0));

  mod_counter #(.WIDTH(5), .MODULUS(10), .PRESCALE(3)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .out(out1), .tc(tc1), .wrap_cnt(w1), .load_err(e1));

  mod_counter #(.WIDTH(1), .MODULUS(2), .PRESCALE(1)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[0:0]), .out(out2), .tc(tc2), .wrap_cnt(w2), .load_err(e2));

  int      total = 0;
  int      fails = 0;
  int      cyc   = 0;
  mstate_t ms[3];
  mstate_t sbq[$];

  function automatic int mod_of(input int k);
    return (k == 2) ? 2 : 10;
  endfunction

  function automatic int pre_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  // Next-state prediction straight from the behavioural description.
  function automatic mstate_t model(input mstate_t s, input int m, input int p,
                                    input int lvv);
    mstate_t n;
    n    = s;
    n.tc = 0;
    if (!rstn) begin
      n.out = 0; n.wrap = 0; n.err = 0; n.pre = 0;
    end else if (clr) begin
      n.out = 0; n.wrap = 0; n.err = 0; n.pre = 0;
    end else if (load) begin
      n.pre = 0;
      if (lvv >= m) begin
        n.out = m - 1;
        n.err = 1;
      end else begin
        n.out = lvv;
      end
    end else if (en) begin
      if (s.pre == p - 1) begin
        n.pre = 0;
        if (up) begin
          if (s.out == m - 1) begin
            if (!SAT_MODE) begin
              n.out = 0; n.tc = 1;
              n.wrap = (s.wrap < 255) ? s.wrap + 1 : 255;
            end
          end else begin
            n.out = s.out + 1;
            if (SAT_MODE && n.out == m - 1) n.tc = 1;
          end
        end else begin
          if (s.out == 0) begin
            if (!SAT_MODE) begin
              n.out = m - 1; n.tc = 1;
              n.wrap = (s.wrap < 255) ? s.wrap + 1 : 255;
            end
          end else begin
            n.out = s.out - 1;
            if (SAT_MODE && n.out == 0) n.tc = 1;
          end
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic c, input logic l, input logic [4:0] v);
    rstn = r; en = e; up = u; clr = c; load = l; lv = v;
  endtask

  // One clock: queue predictions, take the edge, compare after it settles.
  task automatic cycle();
    mstate_t ex;
    logic [31:0] o_out, o_tc, o_w, o_e;
    for (int k = 0; k < 3; k++) begin
      ms[k] = model(ms[k], mod_of(k), pre_of(k), (k == 2) ? int'(lv[0]) : int'(lv));
      sbq.push_back(ms[k]);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      ex = sbq.pop_front();
      case (k)
        0:       begin o_out = {27'b0, out0}; o_tc = {31'b0, tc0}; o_w = {24'b0, w0}; o_e = {31'b0, e0}; end
        1:       begin o_out = {27'b0, out1}; o_tc = {31'b0, tc1}; o_w = {24'b0, w1}; o_e = {31'b0, e1}; end
        default: begin o_out = {31'b0, out2}; o_tc = {31'b0, tc2}; o_w = {24'b0, w2}; o_e = {31'b0, e2}; end
      endcase
      check($sformatf("u%0d_out", k),      o_out, ex.out);
      check($sformatf("u%0d_tc", k),       o_tc,  ex.tc);
      check($sformatf("u%0d_wrap_cnt", k), o_w,   ex.wrap);
      check($sformatf("u%0d_load_err", k), o_e,   ex.err);
    end
    $display("cyc %0d rstn=%b en=%b up=%b clr=%b load=%b lv=%0d | u0 %0d/%b/%0d/%b u1 %0d/%b/%0d/%b u2 %0d/%b/%0d/%b",
             cyc, rstn, en, up, clr, load, lv, out0, tc0, w0, e0,
             out1, tc1, w1, e1, out2, tc2, w2, e2);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) ms[k] = '{0, 0, 0, 0, 0};

    // Reset state.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    run(2);
    check("rst_out0", {27'b0, out0}, 0);
    check("rst_tc0", {31'b0, tc0}, 0);

    // Up-count through one full period.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    run(10);
`ifdef MOD_COUNTER_SAT_EN
    check("up10_out0", {27'b0, out0}, 9);
    check("up10_wrap0", {24'b0, w0}, 0);
`else
    check("up10_out0", {27'b0, out0}, 0);
    check("up10_tc0", {31'b0, tc0}, 1);
    check("up10_wrap0", {24'b0, w0}, 1);
`endif
    run(2);

    // Down-count from reset.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    run(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    run(1);
`ifdef MOD_COUNTER_SAT_EN
    check("dn1_out0", {27'b0, out0}, 0);
    check("dn1_tc0", {31'b0, tc0}, 0);
`else
    check("dn1_out0", {27'b0, out0}, 9);
    check("dn1_tc0", {31'b0, tc0}, 1);
    check("dn1_wrap0", {24'b0, w0}, 1);
`endif
    run(2);

    // Prescaler: step every 3rd enabled cycle; a 2-cycle en gap delays by 2.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    run(1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    run(2);
    check("pre_hold_out1", {27'b0, out1}, 0);
    run(1);
    check("pre_step_out1", {27'b0, out1}, 1);
    run(1);
    en = 1'b0;
    run(2);
    check("pre_gap_out1", {27'b0, out1}, 1);
    check("pre_gap_tc0", {31'b0, tc0}, 0);
    en = 1'b1;
    run(1);
    check("pre_gap_late_out1", {27'b0, out1}, 1);
    run(1);
    check("pre_resume_out1", {27'b0, out1}, 2);

    // Loads: in range, clamped, sticky error, clr beats load.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7);
    run(1);
    check("ld7_out0", {27'b0, out0}, 7);
    check("ld7_err0", {31'b0, e0}, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12);
    run(1);
    check("ld12_out0", {27'b0, out0}, 9);
    check("ld12_err0", {31'b0, e0}, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    run(3);
    check("err_sticky0", {31'b0, e0}, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12);
    run(1);
    check("clrld_out0", {27'b0, out0}, 0);
    check("clrld_err0", {31'b0, e0}, 0);

    // Many wraps on the modulus-2 instance: wrap_cnt saturates.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    run(1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    run(601);
`ifdef MOD_COUNTER_SAT_EN
    check("sat_wrap2", {24'b0, w2}, 0);
    check("sat_out2", {31'b0, out2}, 1);
`else
    check("sat_wrap2", {24'b0, w2}, 255);
`endif
    // Reset mid-count / mid-prescale.
    rstn = 1'b0;
    run(1);
    check("midrst_out0", {27'b0, out0}, 0);
    check("midrst_out1", {27'b0, out1}, 0);
    check("midrst_wrap2", {24'b0, w2}, 0);
    check("midrst_tc2", {31'b0, tc2}, 0);

    // Run up to the top bound, then back down past zero.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    run(12);
    up = 1'b0;
    run(12);

    // Direction changes every cycle with en toggling.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 5'd0);
      cycle();
    end

    // Mixed random traffic.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 14) == 0), 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised modulo up/down counter for cycle and step sequencing in the multi-cycle processor control path.
- Generalises the fixed 5-bit free-running counter: configurable width and modulus, direction, enable, prescaler, synchronous load/clear, terminal-count pulse and wrap counter.
- Drives phase/step indices for the control FSM and timeout logic.

Parameters:
- WIDTH, 5: counter width in bits.
- MODULUS, 32: count range 0..MODULUS-1. Legal range 2..2**WIDTH; elaboration error outside it.
- PRESCALE, 1: one count step per PRESCALE enabled cycles. Legal range 1..256.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  synchronous active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value for load.
- out  out  WIDTH  current count, driven directly from register.
- tc  out  1  terminal-count pulse, registered.
- wrap_cnt  out  8  number of wraps since reset/clr; saturates at 255.
- load_err  out  1  sticky flag: a load requested load_val >= MODULUS.

Behaviour:
- Reset: when rstn=0 at a clock edge, out=0, tc=0, wrap_cnt=0, load_err=0 and the prescaler count (pre) = 0. Reset overrides all other inputs.
- Priority at each edge: rstn, then clr, then load, then step.
- clr:
  - out, wrap_cnt, pre and load_err go to 0; tc=0.
  - en, up and load are ignored that cycle.
- load:
  - out takes load_val, or MODULUS-1 if load_val >= MODULUS; in the clamped case load_err is set.
  - pre goes to 0 and tc=0; wrap_cnt is unchanged.
- Prescaler:
  - pre counts 0..PRESCALE-1 only on cycles with en=1; it holds when en=0.
  - tick = en & (pre==PRESCALE-1). On tick, pre returns to 0.
  - PRESCALE=1: tick=en, and pre is constant 0.
- Step, when tick=1 (up-count):
  - out==MODULUS-1 gives out=0, tc=1, wrap_cnt+1 (saturating).
  - Otherwise out+1.
- Step, when tick=1 (down-count):
  - out==0 gives out=MODULUS-1, tc=1, wrap_cnt+1 (saturating).
  - Otherwise out-1.
- tc:
  - High for exactly one cycle: the cycle in which out first shows the wrapped value.
  - 0 in every other cycle, including cycles with en=0.
- Direction: up may change on any cycle. It is sampled only on tick cycles, with no glitch or extra step.
- Arithmetic: all in WIDTH bits. MODULUS==2**WIDTH wraps naturally, but the comparison against MODULUS-1 is still used.
- Latency: one cycle from any input to out, tc and wrap_cnt.
- Reset mid-prescale or mid-count: all state discarded, no tc.

Optional Feature:
- Macro: MOD_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Up-counting holds at MODULUS-1; down-counting holds at 0.
  - tc pulses for one cycle on the step that arrives at the bound.
  - Further steps at the bound hold the value with tc=0.
  - wrap_cnt stays 0.
- Undefined: wrapping behaviour exactly as described above.

Decomposition:
- Shared package mod_counter_pkg holds:
  - constants WRAP_CNT_W=8 and PRESCALE_MAX=256;
  - the prescaler-width function (clog2 of PRESCALE, minimum 1).
- Sub-module tick_prescaler (params PRESCALE):
  - inputs clk, rstn, en, sync_clr;
  - output tick;
  - owns pre.
- mod_counter instantiates it and asserts sync_clr on clr or load.

Test Plan:
1. WIDTH=5, MODULUS=10, PRESCALE=1, en=1, up=1 from reset → out 0,1,...,9,0; tc high only in the cycle out returns to 0; wrap_cnt=1 after 10 steps.
2. Same config, up=0 from reset → out goes 0→9→8; tc high in the cycle out=9; wrap_cnt increments.
3. PRESCALE=3, en=1 → out steps every 3rd cycle. Drop en for 2 cycles mid-prescale → the step is delayed by exactly 2 cycles.
4. MODULUS=10:
   - load_val=7 → out=7 next cycle, load_err=0.
   - load_val=12 → out=9, load_err=1 and held until clr.
   - clr+load together → out=0, load_err=0.
5. Drive 300 wraps with MODULUS=2 → wrap_cnt saturates at 255. Assert rstn=0 mid-count → next cycle all outputs 0, tc=0.
6. With MOD_COUNTER_SAT_EN, MODULUS=10, up=1 → out saturates at 9 with a single tc pulse on reaching 9; then up=0 counts down to 0, with a single tc pulse on reaching 0; wrap_cnt stays 0.
